// File: rtl/rf_pkg.sv
// Shared types and defaults for the LEGv8 multi-port register file.
package rf_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_t;

    localparam int DEF_DATA_W   = 64;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_ZERO_REG = 31;
    localparam int XZR          = 31;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, issue beats clear.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = DEF_ZERO_REG
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                run,
    input  logic                issue_en,
    input  logic [ADDR_W-1:0]   issue_reg,
    input  logic [1:0]          clr_en,
    input  logic [2*ADDR_W-1:0] clr_reg,
    output logic [NUM_REGS-1:0] busy
);

    logic [NUM_REGS-1:0] busy_d;

    always_comb begin
        busy_d = busy;
        for (int i = 0; i < NUM_REGS; i++) begin
            logic set_i;
            logic clr_i;
            set_i = issue_en && (issue_reg == ADDR_W'(i));
            clr_i = (clr_en[0] && (clr_reg[0 +: ADDR_W] == ADDR_W'(i))) ||
                    (clr_en[1] && (clr_reg[ADDR_W +: ADDR_W] == ADDR_W'(i)));
            if (i == ZERO_REG) begin
                busy_d[i] = 1'b0;
            end else begin
                busy_d[i] = set_i | (busy[i] & ~clr_i);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            busy <= '0;
        end else if (run) begin
            busy <= busy_d;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: clear sweep after reset, dual write, bypass,
// hardwired XZR and a pending-write scoreboard.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int BYPASS   = 1
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic [NUM_RD*ADDR_W-1:0] RD_ADDR,
    output logic [NUM_RD*DATA_W-1:0] RD_DATA,
    output logic [NUM_RD-1:0]        RD_BUSY,
    input  logic [1:0]               WR_EN,
    input  logic [2*ADDR_W-1:0]      WR_ADDR,
    input  logic [2*DATA_W-1:0]      WR_DATA,
    input  logic                     ISSUE_EN,
    input  logic [ADDR_W-1:0]        ISSUE_REG,
    output logic                     READY
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

    rf_state_t           state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                run;
    logic [DATA_W-1:0]   mem [NUM_REGS];
    logic [ADDR_W-1:0]   wa [2];
    logic [DATA_W-1:0]   wd [2];
    logic [1:0]          we;
    logic [NUM_REGS-1:0] busy;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < (ADDR_W+1)'(NUM_REGS)) &&
               (a != ADDR_W'(ZERO_REG));
    endfunction

    assign run   = (state_q == RUN);
    assign READY = run;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_wr
        assign wa[p] = WR_ADDR[p*ADDR_W +: ADDR_W];
        assign wd[p] = WR_DATA[p*DATA_W +: DATA_W];
        assign we[p] = run && WR_EN[p] && addr_ok(wa[p]);
    end

    // Port 1 is written last so it wins on an address collision.
    always_ff @(posedge CLK) begin
        if (RESET_N) begin
            if (!run) begin
                mem[cnt_q] <= '0;
            end else begin
                if (we[0]) mem[wa[0]] <= wd[0];
                if (we[1]) mem[wa[1]] <= wd[1];
            end
        end
    end

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .run       (run),
        .issue_en  (ISSUE_EN),
        .issue_reg (ISSUE_REG),
        .clr_en    (WR_EN),
        .clr_reg   (WR_ADDR),
        .busy      (busy)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        logic              ok;
        logic              hit0;
        logic              hit1;

        assign ra   = RD_ADDR[k*ADDR_W +: ADDR_W];
        assign ok   = run && addr_ok(ra);
        assign hit0 = (BYPASS != 0) && we[0] && (wa[0] == ra);
        assign hit1 = (BYPASS != 0) && we[1] && (wa[1] == ra);

        always_comb begin
            rd = '0;
            if (ok) begin
                if (hit1) begin
                    rd = wd[1];
                end else if (hit0) begin
                    rd = wd[0];
                end else begin
                    rd = mem[ra];
                end
            end
        end

        assign RD_DATA[k*DATA_W +: DATA_W] = rd;
        assign RD_BUSY[k] = ok && busy[ra] && !hit0 && !hit1;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomized self-checking bench for reg_file_mp, bypass and no-bypass builds.
module tb_reg_file_mp;

    localparam int DW  = 64;
    localparam int AW  = 5;
    localparam int NR  = 32;
    localparam int NRD = 2;

    logic               CLK = 1'b0;
    logic               RESET_N;
    logic [NRD*AW-1:0]  RD_ADDR;
    logic [NRD*DW-1:0]  rd_data_b, rd_data_n;
    logic [NRD-1:0]     rd_busy_b, rd_busy_n;
    logic [1:0]         WR_EN;
    logic [2*AW-1:0]    WR_ADDR;
    logic [2*DW-1:0]    WR_DATA;
    logic               ISSUE_EN;
    logic [AW-1:0]      ISSUE_REG;
    logic               ready_b, ready_n;

    int checks = 0;
    int errors = 0;

    logic [63:0] m_mem [NR];
    bit          m_busy [NR];
    bit          m_run;
    int          m_cnt;

    always #5 CLK = ~CLK;

    reg_file_mp #(.BYPASS(1)) u_dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .RD_ADDR(RD_ADDR), .RD_DATA(rd_data_b), .RD_BUSY(rd_busy_b),
        .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .ISSUE_EN(ISSUE_EN), .ISSUE_REG(ISSUE_REG), .READY(ready_b)
    );

    reg_file_mp #(.BYPASS(0)) u_nb (
        .CLK(CLK), .RESET_N(RESET_N),
        .RD_ADDR(RD_ADDR), .RD_DATA(rd_data_n), .RD_BUSY(rd_busy_n),
        .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .ISSUE_EN(ISSUE_EN), .ISSUE_REG(ISSUE_REG), .READY(ready_n)
    );

    function automatic int wad(int p);
        return int'(WR_ADDR[p*AW +: AW]);
    endfunction

    function automatic logic [63:0] exp_rd(int a, bit byp);
        if (!m_run || a == 31) return 64'd0;
        if (byp && WR_EN[1] && wad(1) == a) return WR_DATA[127:64];
        if (byp && WR_EN[0] && wad(0) == a) return WR_DATA[63:0];
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(int a, bit byp);
        if (!m_run) return 1'b0;
        if (byp && ((WR_EN[0] && wad(0) == a) || (WR_EN[1] && wad(1) == a)))
            return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int rnd_reg();
        int v;
        v = $urandom_range(0, 8);
        return (v == 8) ? 31 : v;
    endfunction

    task automatic tick();
        if (!RESET_N) begin
            m_run = 0;
            m_cnt = 0;
            foreach (m_busy[i]) m_busy[i] = 0;
        end else if (!m_run) begin
            m_mem[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == NR) m_run = 1;
        end else begin
            for (int p = 0; p < 2; p++)
                if (WR_EN[p] && wad(p) != 31)
                    m_mem[wad(p)] = WR_DATA[p*DW +: DW];
            for (int p = 0; p < 2; p++)
                if (WR_EN[p]) m_busy[wad(p)] = 0;
            if (ISSUE_EN && ISSUE_REG != 5'd31) m_busy[ISSUE_REG] = 1;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        WR_EN     = '0;
        WR_ADDR   = '0;
        WR_DATA   = '0;
        ISSUE_EN  = 1'b0;
        ISSUE_REG = '0;
        RD_ADDR   = '0;
    endtask

    task automatic set_rd(int a0, int a1);
        RD_ADDR = {AW'(a1), AW'(a0)};
    endtask

    task automatic test_reset();
        int cyc;
        idle();
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        #1;
        checks++;
        if (ready_b !== 1'b0 || rd_busy_b !== 2'b00 || rd_data_b !== '0) begin
            errors++;
            $display("FAIL reset_state: ready=%b busy=%b data=%h want 0", ready_b, rd_busy_b, rd_data_b);
        end
        cyc = 0;
        while (ready_b === 1'b0 && cyc < 40) begin
            WR_EN = 2'($urandom); WR_ADDR = 10'($urandom);
            WR_DATA = {$urandom, $urandom, $urandom, $urandom};
            ISSUE_EN = 1'($urandom); ISSUE_REG = 5'($urandom);
            set_rd(rnd_reg(), rnd_reg());
            #1;
            checks++;
            if (rd_data_b !== '0 || rd_data_n !== '0 || rd_busy_b !== 0 || rd_busy_n !== 0) begin
                errors++;
                $display("FAIL sweep_reads cyc %0d: data=%h/%h busy=%b/%b want 0", cyc, rd_data_b, rd_data_n, rd_busy_b, rd_busy_n);
            end
            tick();
            cyc++;
        end
        idle();
        checks++;
        if (cyc != 32 || ready_n !== 1'b1) begin
            errors++;
            $display("FAIL sweep_len: got %0d cycles ready_n=%b want 32 and 1", cyc, ready_n);
        end
        for (int a = 0; a < NR; a += 2) begin
            set_rd(a, a + 1);
            #1;
            checks++;
            if (rd_data_b !== '0 || rd_data_n !== '0) begin
                errors++;
                $display("FAIL post_sweep R%0d: got %h/%h want 0", a, rd_data_b, rd_data_n);
            end
        end
    endtask

    task automatic test_dual_write();
        WR_EN = 2'b11;
        WR_ADDR = {5'd5, 5'd4};
        WR_DATA = {64'h5, 64'hA};
        tick();
        idle();
        set_rd(4, 5);
        #1;
        checks++;
        if (rd_data_b !== {64'h5, 64'hA} || rd_data_n !== {64'h5, 64'hA}) begin
            errors++;
            $display("FAIL dual_write: got %h/%h want %h", rd_data_b, rd_data_n, {64'h5, 64'hA});
        end
    endtask

    task automatic test_bypass();
        logic [63:0] old;
        old = m_mem[10];
        WR_EN = 2'b01;
        WR_ADDR = {5'd0, 5'd10};
        WR_DATA = {64'h0, 64'hDEADBEEF};
        set_rd(10, 4);
        #1;
        checks++;
        if (rd_data_b[63:0] !== 64'hDEADBEEF) begin
            errors++;
            $display("FAIL bypass_same_cycle: got %h want %h", rd_data_b[63:0], 64'hDEADBEEF);
        end
        checks++;
        if (rd_data_n[63:0] !== old) begin
            errors++;
            $display("FAIL nobypass_same_cycle: got %h want %h", rd_data_n[63:0], old);
        end
        tick();
        idle();
        set_rd(10, 4);
        #1;
        checks++;
        if (rd_data_b[63:0] !== 64'hDEADBEEF || rd_data_n[63:0] !== 64'hDEADBEEF) begin
            errors++;
            $display("FAIL bypass_next_cycle: got %h/%h want deadbeef", rd_data_b[63:0], rd_data_n[63:0]);
        end
    endtask

    task automatic test_same_addr();
        WR_EN = 2'b11;
        WR_ADDR = {5'd7, 5'd7};
        WR_DATA = {64'h2, 64'h1};
        tick();
        WR_EN = 2'b01;
        WR_ADDR = {5'd0, 5'd31};
        WR_DATA = {64'h0, 64'hFF};
        set_rd(31, 7);
        #1;
        checks++;
        if (rd_data_b[63:0] !== 64'h0 || rd_data_n[63:0] !== 64'h0) begin
            errors++;
            $display("FAIL xzr_bypass: got %h/%h want 0", rd_data_b[63:0], rd_data_n[63:0]);
        end
        tick();
        idle();
        set_rd(7, 31);
        #1;
        checks++;
        if (rd_data_b !== {64'h0, 64'h2} || rd_data_n !== {64'h0, 64'h2}) begin
            errors++;
            $display("FAIL same_addr: got %h/%h want %h", rd_data_b, rd_data_n, {64'h0, 64'h2});
        end
    endtask

    task automatic test_scoreboard();
        ISSUE_EN = 1'b1;
        ISSUE_REG = 5'd3;
        tick();
        idle();
        set_rd(3, 4);
        #1;
        checks++;
        if (rd_busy_b !== 2'b01 || rd_busy_n !== 2'b01) begin
            errors++;
            $display("FAIL issue_busy: got %b/%b want 01", rd_busy_b, rd_busy_n);
        end
        WR_EN = 2'b01; WR_ADDR = {5'd0, 5'd3}; WR_DATA = {64'h0, 64'h33};
        ISSUE_EN = 1'b1; ISSUE_REG = 5'd3;
        set_rd(3, 4);
        #1;
        checks++;
        if (rd_busy_b[0] !== 1'b0 || rd_busy_n[0] !== 1'b1) begin
            errors++;
            $display("FAIL busy_same_cycle: got %b/%b want 0/1", rd_busy_b[0], rd_busy_n[0]);
        end
        tick();
        idle();
        set_rd(3, 3);
        #1;
        checks++;
        if (rd_busy_b !== 2'b11 || rd_busy_n !== 2'b11) begin
            errors++;
            $display("FAIL issue_beats_clear: got %b/%b want 11", rd_busy_b, rd_busy_n);
        end
        WR_EN = 2'b10; WR_ADDR = {5'd3, 5'd0}; WR_DATA = {64'h44, 64'h0};
        tick();
        idle();
        ISSUE_EN = 1'b1; ISSUE_REG = 5'd31;
        tick();
        idle();
        set_rd(3, 31);
        #1;
        checks++;
        if (rd_busy_b !== 2'b00 || rd_busy_n !== 2'b00) begin
            errors++;
            $display("FAIL clear_and_xzr: got %b/%b want 00", rd_busy_b, rd_busy_n);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            WR_EN = 2'($urandom);
            WR_ADDR = {AW'(rnd_reg()), AW'(rnd_reg())};
            WR_DATA = {$urandom, $urandom, $urandom, $urandom};
            ISSUE_EN = ($urandom_range(0, 2) == 0);
            ISSUE_REG = AW'(rnd_reg());
            set_rd(rnd_reg(), rnd_reg());
            #1;
            for (int k = 0; k < NRD; k++) begin
                int a;
                a = int'(RD_ADDR[k*AW +: AW]);
                checks++;
                if (rd_data_b[k*DW +: DW] !== exp_rd(a, 1) || rd_data_n[k*DW +: DW] !== exp_rd(a, 0)) begin
                    errors++;
                    $display("FAIL rand_data n%0d port%0d R%0d: got %h/%h want %h/%h", n, k, a,
                             rd_data_b[k*DW +: DW], rd_data_n[k*DW +: DW], exp_rd(a, 1), exp_rd(a, 0));
                end
                checks++;
                if (rd_busy_b[k] !== exp_busy(a, 1) || rd_busy_n[k] !== exp_busy(a, 0)) begin
                    errors++;
                    $display("FAIL rand_busy n%0d port%0d R%0d: got %b/%b want %b/%b", n, k, a,
                             rd_busy_b[k], rd_busy_n[k], exp_busy(a, 1), exp_busy(a, 0));
                end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_reset_midrun();
        int cyc;
        WR_EN = 2'b01; WR_ADDR = {5'd0, 5'd1}; WR_DATA = {64'h0, 64'h55};
        tick();
        idle();
        set_rd(1, 1);
        #1;
        checks++;
        if (rd_data_b[63:0] !== 64'h55) begin
            errors++;
            $display("FAIL pre_reset_r1: got %h want 55", rd_data_b[63:0]);
        end
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        repeat (10) tick();
        checks++;
        if (ready_b !== 1'b0 || ready_n !== 1'b0) begin
            errors++;
            $display("FAIL mid_sweep_ready: got %b/%b want 0", ready_b, ready_n);
        end
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        #1;
        cyc = 0;
        while (ready_b === 1'b0 && cyc < 40) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc != 32) begin
            errors++;
            $display("FAIL restart_sweep_len: got %0d want 32", cyc);
        end
        set_rd(1, 1);
        #1;
        checks++;
        if (rd_data_b !== '0 || rd_data_n !== '0) begin
            errors++;
            $display("FAIL r1_after_reset: got %h/%h want 0", rd_data_b, rd_data_n);
        end
    endtask

    initial begin
        RESET_N = 1'b0;
        idle();
        m_run = 0;
        m_cnt = 0;
        foreach (m_mem[i]) m_mem[i] = '0;
        foreach (m_busy[i]) m_busy[i] = 0;
        @(posedge CLK);
        #1;
        test_reset();
        test_dual_write();
        test_bypass();
        test_same_addr();
        test_scoreboard();
        test_random();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
